accumulator_nb: RTL and testbench
=================================

ACCUMULATOR_NB -- requirements
Module: accumulator_nb

Interface
REQ-001 SHALL have parameter N, default 16: operand, accumulator and result width in bits.
REQ-002 SHALL have parameter COUNT, default 4: operand beats summed per result; legal range 1..2^N-1.
REQ-003 SHALL have port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port in_data, input, N: operand beat.
REQ-006 SHALL have port in_valid, input, 1: in_data is valid.
REQ-007 SHALL have port in_ready, output, 1: the block can accept a beat.
REQ-008 SHALL have port out_data, output, N: accumulated result.
REQ-009 SHALL have port out_valid, output, 1: out_data holds a completed result.
REQ-010 SHALL have port out_ready, input, 1: the consumer takes the result.
REQ-011 SHALL have port out_ovf, output, 1: an adder carry-out occurred during the current result.

Function
REQ-012 SHALL compute acc + in_data with one instance of full_adder_Nb (N passed through, cin tied 0, carry used as overflow); no other adder on the data path.
REQ-013 SHALL implement a 2-state FSM: ACCUM (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-014 SHALL accept a beat only when in_valid=1, in_ready=1 and the FSM is in ACCUM.
REQ-015 SHALL update on each accepted beat: acc <= adder sum; beat counter +1; counter width $clog2(COUNT+1).
REQ-016 SHALL transition ACCUM->HOLD on the clock edge that accepts beat number COUNT; out_valid SHALL rise the following cycle (1-cycle latency); COUNT=1 gives HOLD after every beat.
REQ-017 SHALL drive out_data=acc continuously; in HOLD, out_data and out_ovf SHALL stay stable until the result is taken.
REQ-018 SHALL transition HOLD->ACCUM when out_ready=1 in HOLD, on the same edge clearing acc, the counter and out_ovf to 0.
REQ-019 SHALL ignore in_valid in the HOLD cycle that takes the result (in_ready=0, no bypass); the first beat of the next result is accepted no earlier than the next cycle.
REQ-020 SHALL set out_ovf (sticky) when any accepted beat produces carry=1.
REQ-021 SHALL ignore out_ready in ACCUM; idle cycles (in_valid=0) SHALL leave all state unchanged.

Reset
REQ-022 SHALL, while rst=1 at a clock edge, set FSM=ACCUM, acc=0, counter=0, out_ovf=0; outputs: in_ready=1, out_valid=0, out_data=0, out_ovf=0.
REQ-023 SHALL discard any partial or held result on reset mid-operation; rst SHALL take priority over all handshakes in the same cycle.

Configuration
REQ-024 SHALL honour macro ACC_SATURATE_EN: defined -> on carry=1, acc <= all ones (2^N-1) and subsequent beats stay all ones until handoff; undefined -> acc <= sum modulo 2^N (wrap); out_ovf behaviour identical in both builds.

Verification (N=16, COUNT=4)
REQ-025 SHALL cover: assert rst 2 cycles -> in_ready=1, out_valid=0, out_data=0x0000, out_ovf=0.
REQ-026 SHALL cover: back-to-back beats 1,2,3,4 -> out_valid=1 in the cycle after the 4th beat, out_data=0x000A, out_ovf=0, in_ready=0.
REQ-027 SHALL cover: beats 5,6,7,8 with gaps, then out_ready=0 for 5 cycles -> out_data=0x001A held stable, no beat accepted, then out_ready=1 -> state cleared.
REQ-028 SHALL cover: beats 0xFFFF,0x0002,0x0000,0x0000 -> wrap build: out_data=0x0001, out_ovf=1; ACC_SATURATE_EN build: out_data=0xFFFF, out_ovf=1.
REQ-029 SHALL cover: rst for 1 cycle after 2 beats, then beats 1,1,1,1 -> out_data=0x0004, out_ovf=0.
REQ-030 SHALL cover: out_ready=1 and in_valid=1 (in_data=0x0003) in the same HOLD cycle -> beat not accepted; held beat 0x0003 accepted next cycle; that result starts from 0.

Source files
------------

// File: rtl/accumulator_nb.sv
// accumulator_nb: sums COUNT operand beats into one N-bit result, then holds
// the result until the consumer takes it. Input side and output side use
// valid/ready handshakes; the block never accepts a beat while holding.
//
// Build option: define ACC_SATURATE_EN to clamp the accumulator at all ones
// once any beat carries out; leave it undefined for modulo-2^N wrap.
// out_ovf is the sticky carry flag in both builds.

// Plain N-bit ripple-style adder with carry in/out; the only adder on the
// accumulator data path.
module full_adder_Nb #(
  parameter int N = 16
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_cin,
  output logic [N-1:0] o_sum,
  output logic         o_cout
);

  logic [N:0] w_full;

  assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{N{1'b0}}, i_cin};
  assign o_sum  = w_full[N-1:0];
  assign o_cout = w_full[N];

endmodule

module accumulator_nb #(
  parameter int N     = 16,
  parameter int COUNT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_ovf
);

  localparam int CW = $clog2(COUNT + 1);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [N-1:0]   r_acc;
  logic [CW-1:0]  r_cnt;
  logic           r_ovf;

  logic [N-1:0]   w_sum;
  logic           w_carry;
  logic [N-1:0]   w_acc_nxt;
  logic           w_accept;
  logic           w_last;
  logic           w_take;

`ifdef ACC_SATURATE_EN
  // Clamp to all ones once the running total has exceeded the N-bit range;
  // the sticky flag keeps later beats pinned at the ceiling.
  function automatic logic [N-1:0] sat_acc(input logic [N-1:0] sum,
                                           input logic         sat);
    return sat ? {N{1'b1}} : sum;
  endfunction
`endif

  full_adder_Nb #(
    .N(N)
  ) u_add (
    .i_a   (r_acc),
    .i_b   (in_data),
    .i_cin (1'b0),
    .o_sum (w_sum),
    .o_cout(w_carry)
  );

  // A beat is only taken in ACCUM; the result is only handed off in HOLD.
  assign w_accept = in_valid && (r_state == ACCUM);
  assign w_last   = (r_cnt == CW'(COUNT - 1));
  assign w_take   = out_ready && (r_state == HOLD);

`ifdef ACC_SATURATE_EN
  assign w_acc_nxt = sat_acc(w_sum, w_carry || r_ovf);
`else
  assign w_acc_nxt = w_sum;
`endif

  assign in_ready  = (r_state == ACCUM);
  assign out_valid = (r_state == HOLD);
  assign out_data  = r_acc;
  assign out_ovf   = r_ovf;

  // Next-state logic: move to HOLD on the edge accepting the final beat,
  // back to ACCUM when the consumer takes the result.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ACCUM:   if (w_accept && w_last) w_state_nxt = HOLD;
      HOLD:    if (out_ready)          w_state_nxt = ACCUM;
      default: w_state_nxt = ACCUM;
    endcase
  end

  // State register; reset wins over every handshake.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ACCUM;
    else     r_state <= w_state_nxt;
  end

  // Accumulator, beat counter and sticky overflow; cleared on reset and on
  // handoff, frozen on idle cycles and while holding.
  always_ff @(posedge clk) begin
    if (rst || w_take) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_acc <= w_acc_nxt;
      r_cnt <= r_cnt + CW'(1);
      r_ovf <= r_ovf | w_carry;
    end
  end

endmodule

// File: tb/tb_accumulator_nb.sv
// Bench for accumulator_nb (N=16, COUNT=4): directed scenarios followed by
// random traffic, all outputs compared every cycle against a model that
// tracks the unbounded running total of accepted beats.
module tb_accumulator_nb;

  localparam int N     = 16;
  localparam int COUNT = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_ovf;

  int n_checks = 0;
  int n_errors = 0;

  // Model: holding flag, true (unbounded) sum, accepted beats.
  bit     m_hold = 1'b0;
  longint m_sum  = 0;
  int     m_cnt  = 0;

  always #5 clk = ~clk;

  accumulator_nb #(
    .N    (N),
    .COUNT(COUNT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ovf  (out_ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] m_data();
    longint lim;
    lim = (longint'(1) << N) - 1;
`ifdef ACC_SATURATE_EN
    return (m_sum > lim) ? {N{1'b1}} : N'(m_sum);
`else
    return N'(m_sum & lim);
`endif
  endfunction

  function automatic bit m_ovf();
    return m_sum > ((longint'(1) << N) - 1);
  endfunction

  // One clock: apply the model to the inputs seen at the edge, then compare.
  task automatic cycle(input string tag);
    @(posedge clk);
    if (rst) begin
      m_hold = 1'b0; m_sum = 0; m_cnt = 0;
    end else if (m_hold) begin
      if (out_ready) begin
        m_hold = 1'b0; m_sum = 0; m_cnt = 0;
      end
    end else if (in_valid) begin
      m_sum += longint'(in_data);
      m_cnt++;
      if (m_cnt == COUNT) m_hold = 1'b1;
    end
    #1;
    check({tag, ".in_ready"},  32'(in_ready),  32'(!m_hold));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(m_hold));
    check({tag, ".out_data"},  32'(out_data),  32'(m_data()));
    check({tag, ".out_ovf"},   32'(out_ovf),   32'(m_ovf()));
  endtask

  task automatic drive(input logic v, input logic [N-1:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
  endtask

  task automatic beat(input string tag, input logic [N-1:0] d);
    drive(1'b1, d, 1'b0);
    cycle(tag);
  endtask

  task automatic take(input string tag);
    drive(1'b0, '0, 1'b1);
    cycle(tag);
    out_ready = 1'b0;
  endtask

  logic [N-1:0] v28 [4];

  initial begin
    rst = 1'b1;
    drive(1'b0, '0, 1'b0);

    // Reset for two cycles.
    cycle("rst0");
    cycle("rst1");
    check("rst.out_data", 32'(out_data), 32'h0);
    check("rst.in_ready", 32'(in_ready), 32'h1);
    rst = 1'b0;

    // Back-to-back 1,2,3,4.
    for (int i = 1; i <= 4; i++) beat("b2b", N'(i));
    drive(1'b0, '0, 1'b0);
    check("b2b.sum", 32'(out_data), 32'h000A);
    check("b2b.valid", 32'(out_valid), 32'h1);
    take("b2b.take");

    // 5,6,7,8 with gaps, then held with back-pressure and offered beats.
    for (int i = 5; i <= 8; i++) begin
      beat("gap", N'(i));
      drive(1'b0, '0, 1'b0);
      cycle("gap.idle");
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 16'h0055, 1'b0);
      cycle("hold");
      check("hold.stable", 32'(out_data), 32'h001A);
    end
    take("hold.take");
    check("hold.cleared", 32'(out_data), 32'h0);

    // Carry-out: wrap or saturate.
    v28[0] = 16'hFFFF; v28[1] = 16'h0002; v28[2] = 16'h0000; v28[3] = 16'h0000;
    for (int i = 0; i < 4; i++) beat("ovf", v28[i]);
    drive(1'b0, '0, 1'b0);
`ifdef ACC_SATURATE_EN
    check("ovf.sum", 32'(out_data), 32'hFFFF);
`else
    check("ovf.sum", 32'(out_data), 32'h0001);
`endif
    check("ovf.flag", 32'(out_ovf), 32'h1);
    take("ovf.take");
    check("ovf.cleared", 32'(out_ovf), 32'h0);

    // Reset mid-result.
    beat("mid", 16'h0005);
    beat("mid", 16'h0007);
    rst = 1'b1;
    drive(1'b1, 16'h0009, 1'b1);
    cycle("mid.rst");
    rst = 1'b0;
    for (int i = 0; i < 4; i++) beat("mid.ones", 16'h0001);
    drive(1'b0, '0, 1'b0);
    check("mid.sum", 32'(out_data), 32'h0004);
    check("mid.ovf", 32'(out_ovf), 32'h0);

    // Beat offered in the take cycle: ignored there, accepted next cycle.
    drive(1'b1, 16'h0003, 1'b1);
    cycle("byp.take");
    check("byp.not_taken", 32'(out_data), 32'h0);
    drive(1'b1, 16'h0003, 1'b0);
    cycle("byp.next");
    check("byp.accepted", 32'(out_data), 32'h0003);
    for (int i = 0; i < 3; i++) beat("byp.rest", 16'h0000);
    drive(1'b0, '0, 1'b0);
    check("byp.sum", 32'(out_data), 32'h0003);
    take("byp.done");

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = ($urandom_range(0, 3) == 0) ? N'($urandom_range(16'hF000, 16'hFFFF))
                                              : N'($urandom);
      out_ready = ($urandom_range(0, 2) == 0);
      cycle("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
